// File: rtl/datamemory.sv
// Single-port word-addressed data memory with a registered read port.
// A synchronous active-low reset clears every word and the output in one cycle.
module datamemory #(
    parameter int data_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [ADDR_WIDTH-1:0] ADDR,
    input  logic                  RW_RD,
    input  logic [data_WIDTH-1:0] din,
    output logic [data_WIDTH-1:0] dout
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [data_WIDTH-1:0] mem_q [DEPTH];
    logic [data_WIDTH-1:0] dout_q;
    logic [data_WIDTH-1:0] dout_d;

    // Read-data next state: capture on read, hold during a write (no bypass).
    always_comb begin
        dout_d = dout_q;
        if (RW_RD == 1'b1) begin
            dout_d = mem_q[ADDR];
        end else begin
            dout_d = dout_q;
        end
    end

    // Storage and output register; reset wins over any pending access.
    always_ff @(posedge CLK) begin
        if (RST_N == 1'b0) begin
            dout_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            dout_q <= dout_d;
            if (RW_RD == 1'b0) begin
                mem_q[ADDR] <= din;
            end
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_datamemory.sv
// Self-checking bench for datamemory: directed vector table, a hand-written
// mid-cycle address-change sequence, and randomized traffic against a word-array model.
module tb_datamemory;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 2 ** AW;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] addr;
    logic          rw_rd;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;

    int tests_run;
    int tests_failed;

    logic [DW-1:0] mdl_mem [DEPTH];
    logic [DW-1:0] mdl_dout;

    typedef struct {
        logic          rst_n;
        logic          rw_rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [DW-1:0] exp_dout;
        string         name;
    } vec_t;

    vec_t vecs[$];

    datamemory #(.data_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .ADDR  (addr),
        .RW_RD (rw_rd),
        .din   (din),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        rst_n = r;
        rw_rd = rw;
        addr  = a;
        din   = d;
    endtask

    // Advance one edge; the model applies the rules to whatever the bench is driving.
    task automatic tick();
        @(posedge clk);
        if (rst_n == 1'b0) begin
            for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
            mdl_dout = '0;
        end else if (rw_rd == 1'b1) begin
            mdl_dout = mdl_mem[addr];
        end else begin
            mdl_mem[addr] = din;
        end
        #1;
    endtask

    task automatic add_vec(input logic r, input logic rw, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] e, input string n);
        vec_t v;
        v.rst_n = r; v.rw_rd = rw; v.addr = a; v.din = d; v.exp_dout = e; v.name = n;
        vecs.push_back(v);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        mdl_dout     = '0;
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;

        // Directed table: reset, cleared reads, fill/readback, write-hold, boundaries, reset-during-write.
        add_vec(1'b0, 1'b1, 10'd0,    32'h0,        32'h0,        "reset_dout");
        add_vec(1'b1, 1'b1, 10'd0,    32'h0,        32'h0,        "clr_rd0");
        add_vec(1'b1, 1'b1, 10'd5,    32'h0,        32'h0,        "clr_rd5");
        add_vec(1'b1, 1'b1, 10'd1023, 32'h0,        32'h0,        "clr_rd1023");
        for (int i = 0; i < 15; i++)
            add_vec(1'b1, 1'b0, AW'(i), DW'(i), 32'h0, "fill_wr_hold");
        for (int i = 0; i < 15; i++)
            add_vec(1'b1, 1'b1, AW'(i), 32'h0, DW'(i), "fill_rd");
        add_vec(1'b1, 1'b1, 10'd3,    32'h0,        32'd3,        "rd3");
        add_vec(1'b1, 1'b0, 10'd3,    32'hDEADBEEF, 32'd3,        "wr3_hold");
        add_vec(1'b1, 1'b1, 10'd3,    32'h0,        32'hDEADBEEF, "rd3_new");
        add_vec(1'b1, 1'b0, 10'd1023, 32'hA5A5A5A5, 32'hDEADBEEF, "wr1023_hold");
        add_vec(1'b1, 1'b0, 10'd0,    32'h5A5A5A5A, 32'hDEADBEEF, "wr0_hold");
        add_vec(1'b1, 1'b1, 10'd1023, 32'h0,        32'hA5A5A5A5, "rd1023");
        add_vec(1'b1, 1'b1, 10'd0,    32'h0,        32'h5A5A5A5A, "rd0");
        add_vec(1'b1, 1'b1, 10'd1,    32'h0,        32'd1,        "rd1_untouched");
        add_vec(1'b1, 1'b0, 10'd7,    32'h12345678, 32'd1,        "wr7_hold");
        add_vec(1'b0, 1'b0, 10'd7,    32'hFFFFFFFF, 32'h0,        "rst_during_wr");
        add_vec(1'b1, 1'b1, 10'd7,    32'h0,        32'h0,        "rd7_cleared");
        add_vec(1'b1, 1'b1, 10'd3,    32'h0,        32'h0,        "rd3_cleared");
        add_vec(1'b1, 1'b1, 10'd1023, 32'h0,        32'h0,        "rd1023_cleared");

        drive(1'b1, 1'b1, '0, '0);
        @(negedge clk);
        foreach (vecs[k]) begin
            drive(vecs[k].rst_n, vecs[k].rw_rd, vecs[k].addr, vecs[k].din);
            tick();
            check(vecs[k].name, dout, vecs[k].exp_dout);
        end

        // Mid-cycle address/data changes must not reach dout before the next edge.
        drive(1'b1, 1'b0, 10'd2, 32'h22222222); tick();
        drive(1'b1, 1'b0, 10'd9, 32'h99999999); tick();
        drive(1'b1, 1'b1, 10'd2, 32'h0);        tick();
        check("midchg_first", dout, 32'h22222222);
        #3;
        addr = 10'd9;
        din  = 32'hCAFEF00D;
        #2;
        check("midchg_hold", dout, 32'h22222222);
        tick();
        check("midchg_next", dout, 32'h99999999);
        drive(1'b1, 1'b1, 10'd9, 32'h0); tick(); tick();
        check("repeat_read", dout, 32'h99999999);

        // Randomized traffic against the model, biased toward a small address window.
        drive(1'b0, 1'b1, '0, '0); tick();
        check("rand_reset", dout, mdl_dout);
        for (int n = 0; n < 3000; n++) begin
            logic [AW-1:0] a;
            if ($urandom_range(0, 3) != 0) a = AW'($urandom_range(0, 15));
            else                           a = AW'($urandom);
            drive(($urandom_range(0, 99) != 0), $urandom_range(0, 1) == 1, a, DW'($urandom));
            tick();
            check("rand", dout, mdl_dout);
        end
        drive(1'b1, 1'b1, 10'd1023, '0); tick();
        check("rand_end_1023", dout, mdl_mem[1023]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
